// File: rtl/hydra_mem_arbiter_pkg.sv
// Shared types and constants for the hydra memory arbiter and its helpers.
package hydra_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Read data returned to a core whose downstream access timed out.
    localparam logic [DATA_W-1:0] ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/hydra_mem_arbiter_if.sv
// Downstream native memory bus: the arbiter drives it as master, the
// RAM/LED/UART fabric answers as slave.
interface hydra_mem_arbiter_if;
    import hydra_mem_pkg::*;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/hydra_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index
// found searching upward from last+1, wrapping modulo N_CORES.
module hydra_rr_picker #(
    parameter int N_CORES    = 4,
    parameter int GRANT_BITS = $clog2(N_CORES)
) (
    input  logic [N_CORES-1:0]    req,
    input  logic [GRANT_BITS-1:0] last,
    output logic [GRANT_BITS-1:0] winner,
    output logic                  any_req
);

    // Scan from the farthest candidate back to the nearest so the nearest
    // set bit after last overwrites the others.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = last;
        any_req = |req;
        for (int i = N_CORES; i >= 1; i--) begin
            idx = (int'(last) + i) % N_CORES;
            if (req[idx]) begin
                winner = GRANT_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/hydra_mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory/IO port among several
// picorv32 harts, one transaction at a time, with a watchdog that turns a
// hung downstream access into an error completion.
module hydra_mem_arbiter
    import hydra_mem_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int GRANT_BITS     = $clog2(N_CORES),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_CORES-1:0]         req_valid,
    input  logic [ADDR_W*N_CORES-1:0]  req_addr,
    input  logic [DATA_W*N_CORES-1:0]  req_wdata,
    input  logic [STRB_W*N_CORES-1:0]  req_wstrb,
    output logic [N_CORES-1:0]         req_ready,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       req_err,
    hydra_mem_arbiter_if.master        mem,
    output logic [GRANT_BITS-1:0]      grant_id
);

    state_t                state;
    state_t                state_nx;
    logic [GRANT_BITS-1:0] last;
    logic [GRANT_BITS-1:0] winner;
    logic                  any_req;
    logic [7:0]            tmo_cnt;
    logic                  expire;

    logic [ADDR_W-1:0] addr_arr  [N_CORES];
    logic [DATA_W-1:0] wdata_arr [N_CORES];
    logic [STRB_W-1:0] wstrb_arr [N_CORES];

    hydra_rr_picker #(
        .N_CORES    (N_CORES),
        .GRANT_BITS (GRANT_BITS)
    ) u_picker (
        .req     (req_valid),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );

    // Counter value at which the last allowed BUSY cycle is reached.
    assign expire = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Unpack the flat per-core payload buses so the winner can index them.
    always_comb begin
        for (int k = 0; k < N_CORES; k++) begin
            addr_arr[k]  = req_addr[k*ADDR_W +: ADDR_W];
            wdata_arr[k] = req_wdata[k*DATA_W +: DATA_W];
            wstrb_arr[k] = req_wstrb[k*STRB_W +: STRB_W];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; success wins over a simultaneous timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = BUSY;
            BUSY:    if (mem.mem_ready || expire) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state: request downstream while BUSY, single
    // completion pulse to the granted core while in RESP.
    always_comb begin
        mem.mem_valid = (state == BUSY);
        req_ready     = '0;
        if (state == RESP) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Grant bookkeeping, latched downstream payload, watchdog counter and
    // registered completion data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            grant_id      <= '0;
            last          <= GRANT_BITS'(N_CORES - 1);
            tmo_cnt       <= '0;
            req_rdata     <= '0;
            req_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem.mem_addr  <= addr_arr[winner];
                        mem.mem_wdata <= wdata_arr[winner];
                        mem.mem_wstrb <= wstrb_arr[winner];
                        grant_id      <= winner;
                        last          <= winner;
                        tmo_cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (mem.mem_ready) begin
                        req_rdata <= mem.mem_rdata;
                        req_err   <= 1'b0;
                    end else if (expire) begin
                        req_rdata <= ERR_RDATA;
                        req_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hydra_mem_arbiter.sv
// Directed bench for hydra_mem_arbiter: 4 cores, 8-cycle watchdog.
module tb_hydra_mem_arbiter;
    import hydra_mem_pkg::*;

    localparam int N   = 4;
    localparam int GB  = 2;
    localparam int TMO = 8;

    logic                clk = 1'b0;
    logic                resetn;
    logic [N-1:0]        req_valid;
    logic [ADDR_W*N-1:0] req_addr;
    logic [DATA_W*N-1:0] req_wdata;
    logic [STRB_W*N-1:0] req_wstrb;
    logic [N-1:0]        req_ready;
    logic [DATA_W-1:0]   req_rdata;
    logic                req_err;
    logic [GB-1:0]       grant_id;

    int n_cmp = 0;
    int n_err = 0;

    hydra_mem_arbiter_if mem_if ();

    hydra_mem_arbiter #(
        .N_CORES        (N),
        .GRANT_BITS     (GB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .mem       (mem_if),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] s);
        req_addr[k*32 +: 32] = a;
        req_wdata[k*32 +: 32] = w;
        req_wstrb[k*4 +: 4]   = s;
    endtask

    // Called in IDLE with the request already raised: grant, one-cycle
    // downstream completion, response pulse, return to IDLE.
    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, input logic [31:0] rd, input bit drop);
        tick;
        chk("grant_id", 32'(grant_id), 32'(k));
        chk("mem_valid_busy", 32'(mem_if.mem_valid), 32'd1);
        chk("mem_addr", mem_if.mem_addr, a);
        chk("mem_wdata", mem_if.mem_wdata, w);
        chk("mem_wstrb", 32'(mem_if.mem_wstrb), 32'(s));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = rd;
        tick;
        chk("req_ready_pulse", 32'(req_ready), 32'd1 << k);
        chk("req_rdata", req_rdata, rd);
        chk("req_err_ok", 32'(req_err), 32'd0);
        chk("mem_valid_resp", 32'(mem_if.mem_valid), 32'd0);
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'd0;
        if (drop) req_valid[k] = 1'b0;
        tick;
        chk("req_ready_single", 32'(req_ready), 32'd0);
        chk("mem_valid_idle", 32'(mem_if.mem_valid), 32'd0);
    endtask

    initial begin
        resetn           = 1'b0;
        req_valid        = '0;
        req_addr         = '0;
        req_wdata        = '0;
        req_wstrb        = '0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'd0;
        tick;
        tick;

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
        chk("rst_req_rdata", req_rdata, 32'd0);
        chk("rst_req_err", 32'(req_err), 32'd0);
        resetn = 1'b1;

        // Single read from core 2
        set_req(2, 32'h0000_0010, 32'h0, 4'h0);
        req_valid = 4'b0100;
        txn(2, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b1);

        // Stray mem_ready in IDLE is ignored, response data held
        mem_if.mem_ready = 1'b1;
        tick;
        chk("stray_req_ready", 32'(req_ready), 32'd0);
        chk("stray_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("stray_rdata_held", req_rdata, 32'h1234_5678);
        mem_if.mem_ready = 1'b0;

        // All four cores after reset: order 0,1,2,3
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        set_req(0, 32'h0000_0100, 32'h5000_0000, 4'h0);
        set_req(1, 32'h0000_0104, 32'h5000_0001, 4'h0);
        set_req(2, 32'h0000_0108, 32'h5000_0002, 4'h0);
        set_req(3, 32'h0000_010C, 32'h5000_0003, 4'h0);
        req_valid = 4'b1111;
        txn(0, 32'h0000_0100, 32'h5000_0000, 4'h0, 32'hA000_0000, 1'b1);
        txn(1, 32'h0000_0104, 32'h5000_0001, 4'h0, 32'hA000_0001, 1'b1);
        txn(2, 32'h0000_0108, 32'h5000_0002, 4'h0, 32'hA000_0002, 1'b1);
        txn(3, 32'h0000_010C, 32'h5000_0003, 4'h0, 32'hA000_0003, 1'b1);

        // Fairness: cores 0 and 3 hold their requests
        set_req(0, 32'h0000_0200, 32'h0, 4'h0);
        set_req(3, 32'h0000_020C, 32'h0, 4'h0);
        req_valid = 4'b1001;
        txn(0, 32'h0000_0200, 32'h0, 4'h0, 32'hB000_0000, 1'b0);
        txn(3, 32'h0000_020C, 32'h0, 4'h0, 32'hB000_0003, 1'b0);
        txn(0, 32'h0000_0200, 32'h0, 4'h0, 32'hB000_0010, 1'b0);
        txn(3, 32'h0000_020C, 32'h0, 4'h0, 32'hB000_0013, 1'b0);
        req_valid = 4'b0000;

        // Write pass-through from core 1, payload latched at grant
        set_req(1, 32'h1000_0000, 32'hAABB_CCDD, 4'b0101);
        req_valid = 4'b0010;
        tick;
        chk("wr_grant", 32'(grant_id), 32'd1);
        chk("wr_addr", mem_if.mem_addr, 32'h1000_0000);
        chk("wr_wdata", mem_if.mem_wdata, 32'hAABB_CCDD);
        chk("wr_wstrb", 32'(mem_if.mem_wstrb), 32'h5);
        set_req(1, 32'hDEAD_0000, 32'h0, 4'hF);
        tick;
        chk("wr_hold_valid", 32'(mem_if.mem_valid), 32'd1);
        chk("wr_hold_addr", mem_if.mem_addr, 32'h1000_0000);
        chk("wr_hold_wdata", mem_if.mem_wdata, 32'hAABB_CCDD);
        chk("wr_hold_wstrb", 32'(mem_if.mem_wstrb), 32'h5);
        mem_if.mem_ready = 1'b1;
        tick;
        chk("wr_req_ready", 32'(req_ready), 32'b0010);
        chk("wr_req_err", 32'(req_err), 32'd0);
        mem_if.mem_ready = 1'b0;
        req_valid = 4'b0000;
        tick;

        // Timeout on core 0 with core 2 queued behind it
        set_req(0, 32'h0BAD_0000, 32'h0, 4'h0);
        req_valid = 4'b0001;
        tick;
        chk("tmo_grant", 32'(grant_id), 32'd0);
        chk("tmo_valid_1", 32'(mem_if.mem_valid), 32'd1);
        set_req(2, 32'h0000_0300, 32'h0, 4'h0);
        req_valid[2] = 1'b1;
        for (int i = 2; i <= TMO; i++) begin
            tick;
            chk($sformatf("tmo_valid_%0d", i), 32'(mem_if.mem_valid), 32'd1);
        end
        tick;
        chk("tmo_req_ready", 32'(req_ready), 32'b0001);
        chk("tmo_rdata", req_rdata, 32'hFFFF_FFFF);
        chk("tmo_err", 32'(req_err), 32'd1);
        chk("tmo_valid_drop", 32'(mem_if.mem_valid), 32'd0);
        req_valid[0] = 1'b0;
        tick;
        chk("tmo_ready_clr", 32'(req_ready), 32'd0);
        txn(2, 32'h0000_0300, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);

        // Reset while BUSY on core 3
        set_req(1, 32'h0000_0400, 32'h0, 4'h0);
        set_req(3, 32'h0000_040C, 32'h0, 4'h0);
        req_valid = 4'b1010;
        tick;
        chk("rb_grant", 32'(grant_id), 32'd3);
        chk("rb_valid", 32'(mem_if.mem_valid), 32'd1);
        chk("rb_addr", mem_if.mem_addr, 32'h0000_040C);
        resetn = 1'b0;
        tick;
        chk("rb_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("rb_req_ready", 32'(req_ready), 32'd0);
        chk("rb_grant_id", 32'(grant_id), 32'd0);
        chk("rb_mem_addr", mem_if.mem_addr, 32'd0);
        chk("rb_req_rdata", req_rdata, 32'd0);
        chk("rb_req_err", 32'(req_err), 32'd0);
        resetn = 1'b1;
        set_req(0, 32'h0000_0500, 32'h0, 4'h0);
        req_valid = 4'b1011;
        txn(0, 32'h0000_0500, 32'h0, 4'h0, 32'h0000_5A5A, 1'b1);
        req_valid = 4'b0000;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hydra_mem_arbiter.md
Name: hydra_mem_arbiter

Overview:
- Shares one downstream memory/IO port (on-chip RAM, LED and UART registers) among N_CORES picorv32 harts. Each hart uses the native valid/ready memory interface.
- Fair round-robin grant; one outstanding transaction at a time.
- Downstream payload and upstream read data are registered.
- Watchdog timeout converts a hung downstream access into an error response, so a bad address cannot deadlock the SoC.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- GRANT_BITS, $clog2(N_CORES), width of the grant index.
- TIMEOUT_CYCLES, 255, maximum cycles waiting for mem_ready (1..255).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  N_CORES  per-core request valid.
- req_addr  in  32*N_CORES  per-core byte address, slice k = [32k+31:32k].
- req_wdata  in  32*N_CORES  per-core write data.
- req_wstrb  in  4*N_CORES  per-core byte strobes; all-zero means read.
- req_ready  out  N_CORES  one-cycle completion pulse, at most one bit set.
- req_rdata  out  32  read data, shared by all cores, valid while req_ready is set.
- req_err  out  1  completion was a timeout, qualified by req_ready.
- mem_valid  out  1  downstream request.
- mem_addr  out  32  downstream address.
- mem_wdata  out  32  downstream write data.
- mem_wstrb  out  4  downstream strobes.
- mem_ready  in  1  downstream completion.
- mem_rdata  in  32  downstream read data.
- grant_id  out  GRANT_BITS  index of the current or last granted core (debug).

Behaviour:
- Reset, applied while resetn=0 at a clk edge:
  - state=IDLE; all outputs 0.
  - last pointer = N_CORES-1, so core 0 has first priority.
  - Reset mid-transaction abandons it with no req_ready pulse.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching from last+1 upward, modulo N_CORES.
  - Register that core's addr, wdata and wstrb onto mem_*; set grant_id, last=winner, mem_valid=1, timeout counter=0; go BUSY.
  - If no bit is set, stay IDLE.
- BUSY:
  - mem_valid=1, payload held stable.
  - mem_ready=1: capture mem_rdata into req_rdata, req_err=0, mem_valid<=0, go RESP.
  - Else the counter increments. When it reaches TIMEOUT_CYCLES-1 without mem_ready: req_rdata=32'hFFFF_FFFF, req_err=1, mem_valid<=0, go RESP.
  - mem_ready arriving in the same cycle as expiry is treated as success.
- RESP:
  - req_ready[grant_id]=1 for exactly one cycle; go IDLE.
  - req_rdata and req_err are held until the next RESP.
- Requesters drop req_valid on the edge at which they sample req_ready. The arbiter samples valid again only from IDLE, so the completed request is never re-granted.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_valid from cycle 1.
  - With mem_ready in cycle 1 → req_ready in cycle 2.
  - Minimum 3 cycles per transaction.
- Fairness: a continuously requesting core waits at most N_CORES-1 other transactions.
- Requests from non-granted cores stay pending untouched. Changes to a non-granted core's payload are ignored. The granted core's payload is latched at grant time.
- mem_ready while not in BUSY is ignored.
- Counter is 8 bits; no wrap, since it saturates at expiry.

Decomposition:
- Package hydra_mem_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - ERR_RDATA=32'hFFFF_FFFF;
  - slice helper constants (ADDR_W=32, STRB_W=4).
- One natural sub-module: hydra_rr_picker. It is combinational: from req vector and last pointer, produce winner index and any_req. It is reusable for a future UART/IO arbiter.

Test Plan:
- Single read: core 2 valid, addr 0x0000_0010, wstrb 0; memory returns 0x1234_5678 in cycle 1 → mem_addr=0x10 from cycle 1, req_ready[2] pulse in cycle 2, req_rdata=0x1234_5678, req_err=0.
- Simultaneous requests on all 4 cores after reset → grant order 0,1,2,3 (observed on grant_id); each req_ready is a single pulse; no overlap of mem_valid between grants.
- Fairness: cores 0 and 3 re-request continuously → grants alternate 0,3,0,3; core 3 never waits more than one transaction.
- Write pass-through: core 1 writes wdata 0xAABB_CCDD, wstrb 4'b0101 to 0x1000_0000 → downstream sees an identical payload; req_ready[1] pulses, req_err=0.
- Timeout: core 0 request, mem_ready held 0 with TIMEOUT_CYCLES=8 → mem_valid drops after 8 BUSY cycles; req_ready[0] pulses with req_rdata=0xFFFF_FFFF, req_err=1; next queued core is granted afterwards.
- Reset mid-BUSY: resetn low for 1 cycle during a pending transaction → all outputs 0 next cycle, no req_ready pulse; after release, core 0 wins if multiple cores request.
